uart_shift_unit: RTL and testbench
==================================

# uart_shift_unit

Parametrised full-duplex shift engine for the UART datapath, successor to the fixed 8-bit left-shift register. It accepts a parallel word through a valid/ready handshake and shifts it out serially, one bit per `shift_en` tick. On the same ticks it shifts `ser_in` into the vacated end, so one instance serves the TX path, the RX path, or a loopback. Bit order, width and idle line level are parameters. The unit reports completion with a single-cycle `done` pulse and holds the received word.

## Interface
- `WIDTH`, 8: bits per frame, at least 2.
- `LSB_FIRST`, 1: 1 means bit 0 leaves first; 0 means bit WIDTH-1 leaves first.
- `IDLE_BIT`, 1'b1: level on `ser_out` when not busy.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `shift_en`  in  1  bit-rate tick from the baud generator; ignored in IDLE.
- `abort`  in  1  synchronous cancel of the current frame.
- `load_valid`  in  1  `load_data` is valid.
- `load_data`  in  WIDTH  word to transmit.
- `load_ready`  out  1  unit can accept a word; equals the IDLE state.
- `ser_in`  in  1  serial input, sampled only on accepted ticks.
- `ser_out`  out  1  serial output, registered.
- `busy`  out  1  frame in progress; equals the SHIFT state.
- `done`  out  1  one-cycle pulse marking a completed frame.
- `rx_data`  out  WIDTH  last completed received word.

## Operation
- States:
  - IDLE to SHIFT on `load_valid && load_ready`.
  - SHIFT to IDLE on the WIDTH-th accepted tick, or on `abort`.
- Load: the shift register takes `load_data` and the bit counter clears to 0.
- Each `shift_en` cycle in SHIFT, with `abort`=0:
  - LSB_FIRST=1: shift right; `ser_in` enters bit WIDTH-1.
  - LSB_FIRST=0: shift left; `ser_in` enters bit 0.
  - The counter increments.
- `ser_out`:
  - In SHIFT: the current exit bit, bit 0 when LSB_FIRST=1, otherwise bit WIDTH-1.
  - In IDLE: `IDLE_BIT`.
- Counter width is $clog2(WIDTH+1).
- The frame ends on the tick where the counter goes from WIDTH-1 to WIDTH. On that tick:
  - `rx_data` takes the post-shift register contents. The first received bit lands in bit 0 when LSB_FIRST=1, otherwise in bit WIDTH-1.
  - `done` is registered high for exactly one cycle.
- `abort` in SHIFT: return to IDLE with no `done` pulse; `rx_data` unchanged.
  - `abort` beats a simultaneous `shift_en`.
  - `abort` in IDLE has no effect.
- `load_valid` while busy: not accepted; the upstream holds its data.
- `shift_en` in IDLE: no state, register or counter change.

## Timing
- Reset values:
  - `ser_out`=`IDLE_BIT`, `busy`=0, `load_ready`=1, `done`=0, `rx_data`=0.
  - State IDLE, counter 0, shift register 0.
- Handshake accepted in cycle T:
  - T+1: `busy`=1, `load_ready`=0, `ser_out` = first bit.
  - Each bit holds `ser_out` until the cycle after the next accepted tick.
- Final tick in cycle Tk:
  - Tk+1: `done`=1, `busy`=0, `load_ready`=1, `ser_out`=`IDLE_BIT`, `rx_data` valid.
- Back-to-back frames: a load accepted in the `done` cycle starts the next frame with no gap beyond that one cycle.
- Throughput: continuous `shift_en` completes a frame in WIDTH cycles after the load cycle.
- Reset asserted mid-frame: all outputs go to reset values immediately, with no `done`.
- `ser_in` is assumed synchronised upstream; no synchroniser inside this block.

## Structure
- Shared package `uart_pkg` holds:
  - the state typedef `uart_shift_state_t` (IDLE, SHIFT);
  - the default width constant `UART_DATA_W` = 8.
- Single module. The counter and shift register are small enough to stay inline, so no sub-module.

## Test plan
- LSB-first loopback: WIDTH=8, LSB_FIRST=1, `ser_out` tied to `ser_in`, load 0xA5, continuous `shift_en`.
  - `ser_out` = 1,0,1,0,0,1,0,1.
  - `done` one cycle after the 8th tick; `rx_data`=0xA5.
- MSB-first: LSB_FIRST=0, load 0xA5, `ser_in` driven 0,0,0,0,1,1,1,1.
  - `ser_out` = 1,0,1,0,0,1,0,1; `rx_data`=0x0F.
- Sparse ticks plus busy load: `shift_en` every 16 cycles, second `load_valid` held during the frame.
  - `load_ready`=0 throughout; second word accepted in the `done` cycle.
  - Each bit held exactly 16 cycles.
- Abort: `abort` together with the 3rd `shift_en`.
  - Next cycle: IDLE, `ser_out`=1, no `done`, `rx_data` keeps its previous value.
- Reset mid-frame: assert `rst_n`=0 after 4 bits.
  - Immediately: `ser_out`=1, `busy`=0, `rx_data`=0.
  - After release, a new load of 0x3C completes normally.
- WIDTH=9 parametric run: load 9'h1FF in loopback.
  - `done` after 9 ticks; `rx_data`=9'h1FF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: shift-engine state encoding and the default frame width.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } uart_shift_state_t;

endpackage

// File: rtl/uart_shift_unit.sv
// Full-duplex parametrised shift engine: parallel load, serial out, serial in,
// single-cycle done pulse and a held copy of the last completed received word.
module uart_shift_unit
   import uart_pkg::*;
#(
   parameter int   WIDTH     = UART_DATA_W,
   parameter int   LSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en_i,
   input  logic             abort_i,
   input  logic             load_valid_i,
   input  logic [WIDTH-1:0] load_data_i,
   output logic             load_ready_o,
   input  logic             ser_in_i,
   output logic             ser_out_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] rx_data_o
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   uart_shift_state_t state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [WIDTH-1:0]  shifted;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  rx_q, rx_d;
   logic              done_q, done_d;
   logic              ser_out_q, ser_out_d;

   // Next-state logic; ser_out is computed from the next register contents so
   // the registered output shows the exit bit in the same cycle the bit is current.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      rx_d      = rx_q;
      done_d    = 1'b0;
      ser_out_d = IDLE_BIT;

      if (LSB_FIRST != 0) begin
         shifted = {ser_in_i, shreg_q[WIDTH-1:1]};
      end else begin
         shifted = {shreg_q[WIDTH-2:0], ser_in_i};
      end

      case (state_q)
         IDLE: begin
            if (load_valid_i) begin
               state_d = SHIFT;
               shreg_d = load_data_i;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            // abort takes priority over a coincident tick
            if (abort_i) begin
               state_d = IDLE;
            end else if (shift_en_i) begin
               shreg_d = shifted;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d = IDLE;
                  rx_d    = shifted;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == SHIFT) begin
         ser_out_d = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[WIDTH-1];
      end
   end

   // State, datapath and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         rx_q      <= '0;
         done_q    <= 1'b0;
         ser_out_q <= IDLE_BIT;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         rx_q      <= rx_d;
         done_q    <= done_d;
         ser_out_q <= ser_out_d;
      end
   end

   assign load_ready_o = (state_q == IDLE);
   assign busy_o       = (state_q == SHIFT);
   assign done_o       = done_q;
   assign ser_out_o    = ser_out_q;
   assign rx_data_o    = rx_q;

endmodule

// File: tb/tb_uart_shift_unit.sv
// Directed bench for uart_shift_unit: LSB-first loopback, MSB-first with driven
// input, sparse ticks with a held second load, abort, mid-frame reset, WIDTH=9.
module tb_uart_shift_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // DUT A: WIDTH=8, LSB first, loopback
   logic       en_a = 0, ab_a = 0, lv_a = 0;
   logic [7:0] ld_a = '0;
   logic       rdy_a, so_a, busy_a, done_a;
   logic [7:0] rx_a;

   // DUT B: WIDTH=8, MSB first, driven serial input
   logic       en_b = 0, ab_b = 0, lv_b = 0, si_b = 0;
   logic [7:0] ld_b = '0;
   logic       rdy_b, so_b, busy_b, done_b;
   logic [7:0] rx_b;

   // DUT C: WIDTH=9, LSB first, loopback
   logic       en_c = 0, ab_c = 0, lv_c = 0;
   logic [8:0] ld_c = '0;
   logic       rdy_c, so_c, busy_c, done_c;
   logic [8:0] rx_c;

   uart_shift_unit #(.WIDTH(8), .LSB_FIRST(1), .IDLE_BIT(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .shift_en_i(en_a), .abort_i(ab_a),
      .load_valid_i(lv_a), .load_data_i(ld_a), .load_ready_o(rdy_a),
      .ser_in_i(so_a), .ser_out_o(so_a), .busy_o(busy_a), .done_o(done_a),
      .rx_data_o(rx_a));

   uart_shift_unit #(.WIDTH(8), .LSB_FIRST(0), .IDLE_BIT(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .shift_en_i(en_b), .abort_i(ab_b),
      .load_valid_i(lv_b), .load_data_i(ld_b), .load_ready_o(rdy_b),
      .ser_in_i(si_b), .ser_out_o(so_b), .busy_o(busy_b), .done_o(done_b),
      .rx_data_o(rx_b));

   uart_shift_unit #(.WIDTH(9), .LSB_FIRST(1), .IDLE_BIT(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .shift_en_i(en_c), .abort_i(ab_c),
      .load_valid_i(lv_c), .load_data_i(ld_c), .load_ready_o(rdy_c),
      .ser_in_i(so_c), .ser_out_o(so_c), .busy_o(busy_c), .done_o(done_c),
      .rx_data_o(rx_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are then examined 1 time unit after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // full loopback frame on DUT A with continuous ticks
   task automatic frame_a(input logic [7:0] d, input string tag);
      lv_a = 1; ld_a = d;
      cyc();
      lv_a = 0;
      chk({tag, "_busy"}, busy_a, 1);
      chk({tag, "_rdy"}, rdy_a, 0);
      en_a = 1;
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_so"}, so_a, d[i]);
         chk({tag, "_nodone"}, done_a, 0);
         cyc();
      end
      en_a = 0;
      chk({tag, "_done"}, done_a, 1);
      chk({tag, "_busy_end"}, busy_a, 0);
      chk({tag, "_rdy_end"}, rdy_a, 1);
      chk({tag, "_so_idle"}, so_a, 1);
      chk({tag, "_rx"}, rx_a, d);
      cyc();
      chk({tag, "_done_pulse"}, done_a, 0);
      chk({tag, "_rx_hold"}, rx_a, d);
   endtask

   // full loopback frame on DUT C (WIDTH=9)
   task automatic frame_c(input logic [8:0] d, input string tag);
      lv_c = 1; ld_c = d;
      cyc();
      lv_c = 0;
      chk({tag, "_busy"}, busy_c, 1);
      en_c = 1;
      for (int i = 0; i < 9; i++) begin
         chk({tag, "_so"}, so_c, d[i]);
         chk({tag, "_nodone"}, done_c, 0);
         cyc();
      end
      en_c = 0;
      chk({tag, "_done"}, done_c, 1);
      chk({tag, "_busy_end"}, busy_c, 0);
      chk({tag, "_rx"}, rx_c, d);
      cyc();
      chk({tag, "_done_pulse"}, done_c, 0);
   endtask

   logic seq_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
   logic sin_b  [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
   logic [7:0] w5a = 8'h5A;
   logic [7:0] wc3 = 8'hC3;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      // reset values
      chk("rst_so", so_a, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_rdy", rdy_a, 1);
      chk("rst_done", done_a, 0);
      chk("rst_rx", rx_a, 0);
      rst_n = 1;
      cyc();

      // LSB-first loopback 0xA5 with hand-written bit table
      lv_a = 1; ld_a = 8'hA5;
      cyc();
      lv_a = 0;
      chk("t1_busy", busy_a, 1);
      chk("t1_rdy", rdy_a, 0);
      en_a = 1;
      for (int i = 0; i < 8; i++) begin
         chk("t1_so", so_a, seq_a5[i]);
         chk("t1_nodone", done_a, 0);
         cyc();
      end
      en_a = 0;
      chk("t1_done", done_a, 1);
      chk("t1_busy_end", busy_a, 0);
      chk("t1_so_idle", so_a, 1);
      chk("t1_rx", rx_a, 8'hA5);
      cyc();
      chk("t1_done_pulse", done_a, 0);

      // MSB-first with driven serial input
      lv_b = 1; ld_b = 8'hA5;
      cyc();
      lv_b = 0;
      chk("t2_busy", busy_b, 1);
      en_b = 1;
      for (int i = 0; i < 8; i++) begin
         si_b = sin_b[i];
         chk("t2_so", so_b, seq_a5[i]);
         cyc();
      end
      en_b = 0;
      chk("t2_done", done_b, 1);
      chk("t2_rx", rx_b, 8'h0F);
      chk("t2_so_idle", so_b, 1);
      cyc();
      chk("t2_done_pulse", done_b, 0);

      // sparse ticks every 16 cycles, second load held throughout
      lv_a = 1; ld_a = w5a;
      cyc();
      ld_a = wc3;
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 16; k++) begin
            en_a = (k == 15);
            chk("t3_so_hold", so_a, w5a[i]);
            chk("t3_rdy_low", rdy_a, 0);
            cyc();
         end
      end
      en_a = 0;
      chk("t3_done", done_a, 1);
      chk("t3_rdy_done", rdy_a, 1);
      chk("t3_rx", rx_a, 8'h5A);
      cyc();
      lv_a = 0;
      chk("t3_b2b_busy", busy_a, 1);
      chk("t3_b2b_done_pulse", done_a, 0);
      en_a = 1;
      for (int i = 0; i < 8; i++) begin
         chk("t3_b2b_so", so_a, wc3[i]);
         cyc();
      end
      en_a = 0;
      chk("t3_b2b_done", done_a, 1);
      chk("t3_b2b_rx", rx_a, 8'hC3);
      cyc();

      // abort together with the 3rd tick
      lv_a = 1; ld_a = 8'h0F;
      cyc();
      lv_a = 0;
      en_a = 1;
      cyc();
      cyc();
      ab_a = 1;
      cyc();
      en_a = 0; ab_a = 0;
      chk("t4_busy", busy_a, 0);
      chk("t4_rdy", rdy_a, 1);
      chk("t4_so", so_a, 1);
      chk("t4_nodone", done_a, 0);
      chk("t4_rx_keep", rx_a, 8'hC3);
      cyc();
      chk("t4_nodone2", done_a, 0);
      // abort and tick in IDLE do nothing
      ab_a = 1; en_a = 1;
      cyc();
      ab_a = 0; en_a = 0;
      chk("t4_idle_busy", busy_a, 0);
      chk("t4_idle_so", so_a, 1);
      chk("t4_idle_rx", rx_a, 8'hC3);
      chk("t4_idle_done", done_a, 0);

      // reset after 4 bits
      lv_a = 1; ld_a = 8'h96;
      cyc();
      lv_a = 0;
      en_a = 1;
      repeat (4) cyc();
      chk("t5_pre_busy", busy_a, 1);
      #2 rst_n = 0;
      #1;
      chk("t5_so", so_a, 1);
      chk("t5_busy", busy_a, 0);
      chk("t5_rx", rx_a, 0);
      chk("t5_done", done_a, 0);
      en_a = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      cyc();
      chk("t5_after_done", done_a, 0);
      frame_a(8'h3C, "t5_3c");

      // WIDTH=9 loopback
      frame_c(9'h1FF, "t6_1ff");
      frame_c(9'h12D, "t6_12d");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
